// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stage enables, bubble flushes, halt drain
// sequencing and saturating stall/redirect statistics.
module hazard_controller (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dreq,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_halt,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_wsel,
    input  logic        ex_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halt_out,
    output logic [15:0] stall_cycles,
    output logic [7:0]  redirect_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] stall_q, stall_d;
    logic [7:0]  redir_q, redir_d;

    logic mstall;
    logic lu;

    assign mstall = mem_dreq & ~dhit;
    assign lu = ex_memRead & (ex_wsel != 5'd0) &
                ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        stall_d    = stall_q;
        redir_d    = redir_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halt_out   = 1'b0;
        if (nRST) begin
            unique case (state_q)
                RUN: begin
                    if (mstall) begin
                        // full freeze; a pending redirect is retried later
                    end else if (ex_redirect) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        if (redir_q != 8'hFF)
                            redir_d = redir_q + 8'd1;
                    end else if (lu) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        // halt entry and fetch miss share the same shape
                        pc_en      = ~(id_halt | ~ihit);
                        ifid_en    = 1'b1;
                        ifid_flush = id_halt | ~ihit;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        if (id_halt) begin
                            state_d = DRAIN;
                            drain_d = 2'd3;
                        end
                    end
                    if (!pc_en && stall_q != 16'hFFFF)
                        stall_d = stall_q + 16'd1;
                end
                DRAIN: begin
                    if (!mstall) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        drain_d    = drain_q - 2'd1;
                        if (drain_q == 2'd1)
                            state_d = HALTED;
                    end
                end
                HALTED: begin
                    halt_out = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= 2'd0;
            stall_q <= 16'd0;
            redir_q <= 8'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            redir_q <= redir_d;
        end
    end

    assign stall_cycles   = stall_q;
    assign redirect_count = redir_q;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 CLK  in  1  rising-edge clock, only clock.
REQ-003 nRST  in  1  synchronous active-low reset, sampled on CLK rise.
REQ-004 ihit  in  1  instruction fetch completed this cycle.
REQ-005 dhit  in  1  data access of MEM-stage instruction completed this cycle.
REQ-006 mem_dreq  in  1  MEM-stage instruction requests data memory.
REQ-007 id_rs, id_rt  in  5 each  source register selects of decode instruction.
REQ-008 id_uses_rt  in  1  decode instruction reads rt.
REQ-009 id_halt  in  1  decode instruction is halt.
REQ-010 ex_memRead  in  1  execute instruction is a load.
REQ-011 ex_wsel  in  5  destination register of execute instruction.
REQ-012 ex_redirect  in  1  taken branch or jump resolved in execute; PC mux selects target.
REQ-013 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables.
REQ-014 ifid_flush, idex_flush  out  1 each  load bubble (all-zero/nop) into that latch when its enable is 1.
REQ-015 halt_out  out  1  CPU halted.
REQ-016 stall_cycles  out  16  cycles with pc_en=0 while in RUN.
REQ-017 redirect_count  out  8  accepted redirects.

Function
REQ-018 Terms: mstall = mem_dreq & ~dhit; lu = ex_memRead & (ex_wsel!=0) & ((ex_wsel==id_rs) | (id_uses_rt & ex_wsel==id_rt)).
REQ-019 States RUN, DRAIN, HALTED; drain_cnt is 2-bit.
REQ-020 RUN priority 1, mstall: all enables 0, flushes 0.
REQ-021 RUN priority 2, ex_redirect: all enables 1, ifid_flush=1, idex_flush=1; redirect_count +1.
REQ-022 RUN priority 3, lu: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1; one bubble per hazard, since the load leaves EX next cycle.
REQ-023 RUN priority 4, ~ihit: pc_en=0, ifid_en=1, ifid_flush=1, remaining enables 1.
REQ-024 RUN otherwise: all enables 1, flushes 0.
REQ-025 RUN to DRAIN when id_halt & ~mstall & ~ex_redirect & ~lu; at that edge drain_cnt<=3.
REQ-026 Same cycle as REQ-025, halt advances to ID/EX: all enables 1, pc_en=0, ifid_flush=1.
REQ-027 DRAIN with mstall: all enables 0.
REQ-028 DRAIN otherwise: pc_en=0, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=memwb_en=1; drain_cnt decrements.
REQ-029 DRAIN to HALTED on an advancing cycle with drain_cnt==1.
REQ-030 DRAIN ignores ex_redirect and lu.
REQ-031 HALTED: all enables 0, flushes 0, halt_out=1; state held until reset.
REQ-032 stall_cycles increments on each RUN cycle with pc_en=0, including mstall cycles.
REQ-033 stall_cycles and redirect_count saturate at all-ones and do not wrap.
REQ-034 ex_wsel==0 never triggers lu.
REQ-035 Simultaneous mstall and ex_redirect: freeze only; redirect counted in the later cycle it is accepted.

Reset
REQ-036 nRST=0 at CLK rise: state<=RUN, drain_cnt<=0, counters<=0.
REQ-037 While nRST=0: all enables 0, flushes 0, halt_out=0.
REQ-038 Reset asserted in any state, including mid-DRAIN or HALTED, returns to RUN.

Verification
REQ-039 ex_memRead=1, ex_wsel=5, id_rs=5, ihit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cycles=1.
REQ-040 ex_redirect=1 with lu=1 in the same cycle -> ifid_flush=idex_flush=1, pc_en=1, redirect_count=1, stall_cycles unchanged.
REQ-041 mem_dreq=1, dhit=0 for 4 cycles, then dhit=1 -> 4 cycles all enables 0, stall_cycles=4, normal advance on the 5th cycle.
REQ-042 id_halt=1 with no hazards, no mstall -> DRAIN; halt_out=1 exactly 4 cycles after id_halt sampled. One mstall cycle mid-drain -> 5 cycles.
REQ-043 Preload stall_cycles to 0xFFFF via 65535 ~ihit cycles, apply one more -> stall_cycles stays 0xFFFF.
REQ-044 nRST=0 for one edge while HALTED -> halt_out=0 and RUN next cycle, counters 0.
